// File: rtl/mdio_proxy_bridge.sv
// APB-to-APB bridge: local proxy window for indirect wide-address access,
// plus prefixed bypass forwarding, both with a programmable timeout.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   req_p*                          APB request port (from MDIO side)
//   out_p*                          APB output port (to mapper)
module mdio_proxy_bridge #(
    parameter int                REQ_AW     = 21,
    parameter int                OUT_AW     = 32,
    parameter int                DW         = 16,
    parameter logic [REQ_AW-1:0] PROXY_BASE = 21'h1F_FFFC,
    parameter int                BYP_PREFIX = 1,
    parameter int                TW         = 10,
    parameter int                TIMEOUT    = 1000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [REQ_AW-1:0] req_paddr,
    input  logic              req_pwrite,
    input  logic              req_psel,
    input  logic              req_penable,
    input  logic [DW-1:0]     req_pwdata,
    output logic              req_pready,
    output logic [DW-1:0]     req_prdata,
    output logic              req_pslverr,
    output logic [OUT_AW-1:0] out_paddr,
    output logic              out_pwrite,
    output logic              out_psel,
    output logic              out_penable,
    output logic [DW-1:0]     out_pwdata,
    input  logic              out_pready,
    input  logic [DW-1:0]     out_prdata,
    input  logic              out_pslverr
);

    typedef enum logic [2:0] {
        IDLE, REG_ACK, BYP_SETUP, BYP_ACCESS, PX_SETUP, PX_ACCESS, DONE_ACK
    } state_t;

    localparam logic [OUT_AW-1:0] PFX = OUT_AW'(BYP_PREFIX) << REQ_AW;

    state_t          state;
    logic [TW-1:0]   cnt;
    logic [DW-1:0]   data_q;
    logic [DW-1:0]   addr_h_q;
    logic [DW-1:0]   addr_l_q;
    logic            go_q, wr_q, done_q, err_q, tmo_q;

    logic            hit;
    logic [DW-1:0]   ctrl_rd;
    logic [DW-1:0]   reg_rd;
    logic [TW-1:0]   cnt_nxt;
    logic            tmo_hit;
    logic            acc;
    logic            fin;
    logic [2*DW-1:0] px_addr;

    always_comb begin
        hit     = req_paddr[REQ_AW-1:2] == PROXY_BASE[REQ_AW-1:2];
        ctrl_rd = {{(DW-5){1'b0}}, tmo_q, err_q, done_q, wr_q, go_q};
        reg_rd  = '0;
        unique case (req_paddr[1:0])
            2'd0: reg_rd = data_q;
            2'd1: reg_rd = addr_h_q;
            2'd2: reg_rd = addr_l_q;
            2'd3: reg_rd = ctrl_rd;
        endcase
        cnt_nxt = cnt + 1'b1;
        // out_pready wins over a simultaneous timeout
        tmo_hit = cnt_nxt == TW'(TIMEOUT);
        acc     = (state == BYP_ACCESS) || (state == PX_ACCESS);
        fin     = acc && (out_pready || tmo_hit);
        px_addr = {addr_h_q, addr_l_q};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            data_q      <= '0;
            addr_h_q    <= '0;
            addr_l_q    <= '0;
            go_q        <= 1'b0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            req_pready  <= 1'b0;
            req_prdata  <= '0;
            req_pslverr <= 1'b0;
            out_paddr   <= '0;
            out_pwrite  <= 1'b0;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            out_pwdata  <= '0;
        end else begin
            req_pready  <= 1'b0;
            req_prdata  <= '0;
            req_pslverr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_psel && req_penable) begin
                        if (hit) begin
                            state      <= REG_ACK;
                            req_pready <= 1'b1;
                            if (req_pwrite) begin
                                unique case (req_paddr[1:0])
                                    2'd0: data_q   <= req_pwdata;
                                    2'd1: addr_h_q <= req_pwdata;
                                    2'd2: addr_l_q <= req_pwdata;
                                    2'd3: begin
                                        go_q <= req_pwdata[0];
                                        wr_q <= req_pwdata[1];
                                        // launching clears the status bits
                                        if (req_pwdata[0]) begin
                                            done_q <= 1'b0;
                                            err_q  <= 1'b0;
                                            tmo_q  <= 1'b0;
                                        end
                                    end
                                endcase
                            end else begin
                                req_prdata <= reg_rd;
                            end
                        end else begin
                            state      <= BYP_SETUP;
                            out_psel   <= 1'b1;
                            out_paddr  <= PFX | OUT_AW'(req_paddr);
                            out_pwrite <= req_pwrite;
                            out_pwdata <= req_pwdata;
                        end
                    end
                end
                REG_ACK: begin
                    // go is only ever set by the CTRL write just acknowledged
                    if (go_q) begin
                        state      <= PX_SETUP;
                        out_psel   <= 1'b1;
                        out_paddr  <= px_addr[OUT_AW-1:0];
                        out_pwrite <= wr_q;
                        out_pwdata <= data_q;
                    end else begin
                        state <= IDLE;
                    end
                end
                BYP_SETUP: begin
                    state       <= BYP_ACCESS;
                    out_penable <= 1'b1;
                    cnt         <= '0;
                end
                PX_SETUP: begin
                    state       <= PX_ACCESS;
                    out_penable <= 1'b1;
                    cnt         <= '0;
                end
                BYP_ACCESS: begin
                    if (out_pready) begin
                        state       <= DONE_ACK;
                        req_pready  <= 1'b1;
                        req_prdata  <= out_pwrite ? '0 : out_prdata;
                        req_pslverr <= out_pslverr;
                    end else if (tmo_hit) begin
                        state       <= DONE_ACK;
                        req_pready  <= 1'b1;
                        req_prdata  <= '1;
                        req_pslverr <= 1'b1;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                PX_ACCESS: begin
                    if (out_pready) begin
                        state  <= IDLE;
                        go_q   <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= out_pslverr;
                        if (!out_pwrite) data_q <= out_prdata;
                    end else if (tmo_hit) begin
                        state  <= IDLE;
                        go_q   <= 1'b0;
                        done_q <= 1'b1;
                        tmo_q  <= 1'b1;
                        err_q  <= 1'b1;
                        if (!out_pwrite) data_q <= '1;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                DONE_ACK: state <= IDLE;
                default:  state <= IDLE;
            endcase
            if (fin) begin
                out_psel    <= 1'b0;
                out_penable <= 1'b0;
                out_paddr   <= '0;
                out_pwrite  <= 1'b0;
                out_pwdata  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mdio_proxy_bridge.sv
// Directed self-checking bench for mdio_proxy_bridge.
// Drives the request port, models a configurable output-side slave.
module tb_mdio_proxy_bridge;

    localparam logic [20:0] A_DATA = 21'h1F_FFFC;
    localparam logic [20:0] A_AH   = 21'h1F_FFFD;
    localparam logic [20:0] A_AL   = 21'h1F_FFFE;
    localparam logic [20:0] A_CTRL = 21'h1F_FFFF;

    logic        clk, rstn;
    logic [20:0] req_paddr;
    logic        req_pwrite, req_psel, req_penable;
    logic [15:0] req_pwdata;
    logic        req_pready;
    logic [15:0] req_prdata;
    logic        req_pslverr;
    logic [31:0] out_paddr;
    logic        out_pwrite, out_psel, out_penable;
    logic [15:0] out_pwdata;
    logic        out_pready;
    logic [15:0] out_prdata;
    logic        out_pslverr;

    mdio_proxy_bridge #(.TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .req_paddr(req_paddr), .req_pwrite(req_pwrite),
        .req_psel(req_psel), .req_penable(req_penable),
        .req_pwdata(req_pwdata), .req_pready(req_pready),
        .req_prdata(req_prdata), .req_pslverr(req_pslverr),
        .out_paddr(out_paddr), .out_pwrite(out_pwrite),
        .out_psel(out_psel), .out_penable(out_penable),
        .out_pwdata(out_pwdata), .out_pready(out_pready),
        .out_prdata(out_prdata), .out_pslverr(out_pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // output-side slave model
    bit          sl_silent = 0;
    int          sl_wait = 0;
    logic [15:0] sl_rdata = '0;
    logic        sl_err = 0;
    int          sl_cnt = 0;
    int          sl_acc = 0;
    int          n_txn = 0;
    bit          prev_setup = 0;
    bit          sl_setup_ok = 0;
    logic [31:0] sl_addr = '0;
    logic        sl_write = 0;
    logic [15:0] sl_wdata = '0;
    logic [31:0] txq[$];

    initial begin
        out_pready  = 1'b0;
        out_prdata  = '0;
        out_pslverr = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (out_psel && out_penable) begin
                if (sl_cnt == 0) begin
                    n_txn++;
                    sl_addr     = out_paddr;
                    sl_write    = out_pwrite;
                    sl_wdata    = out_pwdata;
                    sl_setup_ok = prev_setup;
                    txq.push_back(out_paddr);
                end
                sl_acc = sl_cnt + 1;
                if (!sl_silent && sl_cnt == sl_wait) begin
                    out_pready  = 1'b1;
                    out_prdata  = sl_rdata;
                    out_pslverr = sl_err;
                end else begin
                    out_pready  = 1'b0;
                    out_prdata  = '0;
                    out_pslverr = 1'b0;
                end
                sl_cnt++;
            end else begin
                sl_cnt      = 0;
                out_pready  = 1'b0;
                out_prdata  = '0;
                out_pslverr = 1'b0;
            end
            prev_setup = out_psel && !out_penable;
        end
    end

    task automatic apb(input logic [20:0] a, input logic w,
                       input logic [15:0] wd, output logic [15:0] rd,
                       output logic er, output int lat);
        @(negedge clk);
        req_paddr   = a;
        req_pwrite  = w;
        req_pwdata  = wd;
        req_psel    = 1'b1;
        req_penable = 1'b0;
        @(negedge clk);
        req_penable = 1'b1;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (req_pready) begin
                rd = req_prdata;
                er = req_pslverr;
                break;
            end
            if (lat > 500) begin
                chk("req_pready_bound", req_pready, 1);
                break;
            end
        end
        req_psel    = 1'b0;
        req_penable = 1'b0;
    endtask

    logic [15:0] rd;
    logic        er;
    int          lat;
    int          t0;
    bit          seen;

    initial begin
        rstn = 1'b0;
        req_paddr = '0; req_pwrite = 0; req_psel = 0;
        req_penable = 0; req_pwdata = '0;
        #23;
        chk("rst_ctl", {out_psel, out_penable, out_pwrite,
                        req_pready, req_pslverr}, 0);
        chk("rst_paddr", out_paddr, 0);
        chk("rst_prdata", req_prdata, 0);
        @(negedge clk);
        rstn = 1'b1;
        apb(A_CTRL, 0, 0, rd, er, lat);
        chk("rst_ctrl_reg", rd, 16'h0000);

        // proxy write
        apb(A_AH, 1, 16'h0001, rd, er, lat);
        apb(A_AL, 1, 16'h2345, rd, er, lat);
        apb(A_DATA, 1, 16'hBEEF, rd, er, lat);
        t0 = n_txn;
        apb(A_CTRL, 1, 16'h0003, rd, er, lat);
        chk("ctrl_wr_ack", {er, rd}, 0);
        apb(A_CTRL, 0, 0, rd, er, lat);
        chk("pxw_ctrl", rd, 16'h0006);
        chk("pxw_ntxn", n_txn - t0, 1);
        chk("pxw_addr", sl_addr, 32'h0001_2345);
        chk("pxw_dir_data", {sl_write, sl_wdata}, {1'b1, 16'hBEEF});
        chk("pxw_setup", sl_setup_ok, 1);

        // proxy read with 3 wait cycles
        sl_wait = 3; sl_rdata = 16'hA5A5;
        apb(A_AH, 1, 16'h0000, rd, er, lat);
        apb(A_AL, 1, 16'h0010, rd, er, lat);
        apb(A_CTRL, 1, 16'h0001, rd, er, lat);
        apb(A_DATA, 0, 0, rd, er, lat);
        chk("pxr_data", rd, 16'hA5A5);
        apb(A_CTRL, 0, 0, rd, er, lat);
        chk("pxr_ctrl", rd, 16'h0004);
        chk("pxr_acc", sl_acc, 4);
        chk("pxr_addr_dir", {sl_addr, sl_write}, {32'h0000_0010, 1'b0});

        // bypass read
        sl_wait = 0; sl_rdata = 16'h1234;
        apb(21'h00_0100, 0, 0, rd, er, lat);
        chk("byp_rd", {er, rd}, {1'b0, 16'h1234});
        chk("byp_addr", sl_addr, 32'h0020_0100);
        @(posedge clk); #1;
        chk("byp_pulse", {req_pready, req_prdata}, 0);

        // bypass timeout and last-cycle completion
        sl_silent = 1;
        apb(21'h00_0200, 0, 0, rd, er, lat);
        chk("byp_tmo", {er, rd}, {1'b1, 16'hFFFF});
        chk("byp_tmo_acc", sl_acc, 8);
        sl_silent = 0; sl_wait = 7; sl_rdata = 16'h5A5A;
        apb(21'h00_0200, 0, 0, rd, er, lat);
        chk("byp_edge", {er, rd}, {1'b0, 16'h5A5A});
        chk("byp_edge_acc", sl_acc, 8);

        // bypass write with slave error
        sl_wait = 0; sl_err = 1;
        apb(21'h00_0300, 1, 16'h7777, rd, er, lat);
        chk("bypw_err", {er, rd}, {1'b1, 16'h0000});
        chk("bypw_out", {sl_write, sl_wdata}, {1'b1, 16'h7777});

        // proxy error, sticky bits, relaunch clears
        apb(A_CTRL, 1, 16'h0003, rd, er, lat);
        apb(A_CTRL, 0, 0, rd, er, lat);
        chk("pxe_ctrl", rd, 16'h000E);
        apb(A_CTRL, 1, 16'h0000, rd, er, lat);
        apb(A_CTRL, 0, 0, rd, er, lat);
        chk("pxe_sticky", rd, 16'h000C);
        sl_err = 0;
        apb(A_CTRL, 1, 16'h0001, rd, er, lat);
        apb(A_CTRL, 0, 0, rd, er, lat);
        chk("pxe_clear", rd, 16'h0004);

        // proxy timeout on read
        sl_silent = 1;
        apb(A_CTRL, 1, 16'h0001, rd, er, lat);
        apb(A_DATA, 0, 0, rd, er, lat);
        chk("pxt_data", rd, 16'hFFFF);
        apb(A_CTRL, 0, 0, rd, er, lat);
        chk("pxt_ctrl", rd, 16'h001C);
        sl_silent = 0;

        // bypass stalls behind a proxy transaction
        sl_wait = 5; sl_rdata = 16'h2222;
        apb(A_AL, 1, 16'h0040, rd, er, lat);
        txq.delete();
        apb(A_CTRL, 1, 16'h0001, rd, er, lat);
        apb(21'h00_0500, 0, 0, rd, er, lat);
        chk("stall_rd", {er, rd}, {1'b0, 16'h2222});
        chk("stall_lat", lat > 7, 1);
        chk("stall_n", txq.size(), 2);
        if (txq.size() == 2) begin
            chk("stall_first", txq[0], 32'h0000_0040);
            chk("stall_second", txq[1], 32'h0020_0500);
        end

        // reset in the middle of BYP_ACCESS
        sl_wait = 0;
        apb(A_DATA, 1, 16'h1357, rd, er, lat);
        sl_silent = 1;
        @(negedge clk);
        req_paddr = 21'h00_0600; req_pwrite = 0;
        req_psel = 1; req_penable = 0;
        @(negedge clk);
        req_penable = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            seen = out_penable;
        end
        chk("rst_mid_access", seen, 1);
        rstn = 1'b0;
        req_psel = 0; req_penable = 0;
        #1;
        chk("rst_mid_out", {out_psel, out_penable, out_paddr}, 0);
        @(posedge clk); #1;
        chk("rst_mid_req", {req_pready, req_pslverr, req_prdata}, 0);
        @(negedge clk);
        rstn = 1'b1;
        sl_silent = 0;
        apb(A_DATA, 0, 0, rd, er, lat);
        chk("rst_mid_data", rd, 16'h0000);
        apb(A_AL, 0, 0, rd, er, lat);
        chk("rst_mid_addrl", rd, 16'h0000);
        apb(A_CTRL, 0, 0, rd, er, lat);
        chk("rst_mid_ctrl", rd, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mdio_proxy_bridge.md
Name: mdio_proxy_bridge

Overview:
- Parametrised APB-to-APB bridge between the MDIO Clause 22/45 request port and the APB mapper.
- Requests that fall in a 4-word proxy window are served from local proxy registers: DATA, ADDR_H, ADDR_L and CTRL.
- Writing CTRL with go=1 launches one indirect transaction on the output bus, with full address width.
- All other requests are forwarded (bypass), with an address prefix prepended.
- Both output paths have a programmable timeout and report errors back to the requester.

Parameters:
- REQ_AW, 21, request address width.
- OUT_AW, 32, output address width; must be <= 2*DW and >= REQ_AW.
- DW, 16, data width.
- PROXY_BASE, 21'h1F_FFFC, base of the proxy window; bits [1:0] must be 0. Offsets: +0 DATA, +1 ADDR_H, +2 ADDR_L, +3 CTRL.
- BYP_PREFIX, 1, value placed in out_paddr[OUT_AW-1:REQ_AW] for bypass accesses.
- TW, 10, timeout counter width.
- TIMEOUT, 1000, number of ACCESS cycles without out_pready before abort; range 1..2^TW-1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_paddr  in  REQ_AW  request address.
- req_pwrite  in  1  request direction (1 = write).
- req_psel  in  1  request select.
- req_penable  in  1  request enable.
- req_pwdata  in  DW  request write data.
- req_pready  out  1  one-cycle completion pulse.
- req_prdata  out  DW  read data, valid while req_pready=1.
- req_pslverr  out  1  error, valid while req_pready=1.
- out_paddr  out  OUT_AW  output address.
- out_pwrite  out  1  output direction.
- out_psel  out  1  output select.
- out_penable  out  1  output enable.
- out_pwdata  out  DW  output write data.
- out_pready  in  1  output ready.
- out_prdata  in  DW  output read data.
- out_pslverr  in  1  output error.

Behaviour:
- Reset: all outputs 0; all proxy registers 0; FSM in IDLE; timeout counter 0.
- All outputs are driven from registers (no combinational path from inputs to outputs).
- A request is accepted in IDLE when req_psel & req_penable. The requester holds the request until req_pready. No new request is accepted outside IDLE.
- Proxy hit: req_paddr[REQ_AW-1:2] == PROXY_BASE[REQ_AW-1:2].
- CTRL bit map: [0] go, self-clearing; [1] wr; [2] done, sticky; [3] err, sticky; [4] tmo, sticky; [DW-1:5] read as 0.
- FSM states: IDLE, REG_ACK, BYP_SETUP, BYP_ACCESS, PX_SETUP, PX_ACCESS, DONE_ACK.
- IDLE, proxy hit: register write or read-sample happens at acceptance; next state REG_ACK.
- REG_ACK: req_pready=1, req_pslverr=0. req_prdata carries the register value sampled at acceptance (0 for writes).
  - Next state is PX_SETUP if the access wrote CTRL with req_pwdata[0]=1, otherwise IDLE.
  - A CTRL write with go=1 loads wr and clears done, err and tmo.
  - A CTRL write with go=0 writes bits [1:0] only; done, err and tmo stay sticky.
- IDLE, non-hit: latch address, direction and data; next state BYP_SETUP. Output address = {BYP_PREFIX, req_paddr}.
- SETUP states: out_psel=1, out_penable=0. Address, direction and data are valid and held stable through ACCESS. Next state is the matching ACCESS state; timeout counter cleared.
- ACCESS states: out_psel=1, out_penable=1. Counter increments each cycle while out_pready=0. Completion on out_pready=1; abort when counter reaches TIMEOUT.
- If out_pready=1 and counter==TIMEOUT occur in the same cycle, this is a normal completion (no timeout).
- Bypass completion:
  - Capture prdata (reads only) and pslverr; next state DONE_ACK.
  - On timeout, prdata = all ones and pslverr=1.
  - DONE_ACK: req_pready=1 with the captured prdata/pslverr; next state IDLE.
- Proxy transaction:
  - Output address = {ADDR_H, ADDR_L}[OUT_AW-1:0]; direction = CTRL.wr; write data = DATA.
  - Completion: go<=0, done<=1, err<=out_pslverr. On a read, DATA<=out_prdata. Next state IDLE.
  - Timeout: go<=0, done<=1, tmo<=1, err<=1. On a read, DATA<=all ones.
  - No req_pready is generated (the CTRL write was already acknowledged in REG_ACK).
  - Requests arriving during PX_* stall until the FSM returns to IDLE.
- out_* are all zero outside the SETUP/ACCESS states. req_pready is 0 outside REG_ACK and DONE_ACK, and req_prdata/req_pslverr are 0 whenever req_pready=0.
- Reset asserted mid-transaction: the FSM aborts immediately, out_psel drops, and no completion is reported.

Test Plan:
- Write ADDR_H=16'h0001, ADDR_L=16'h2345, DATA=16'hBEEF, then CTRL=16'h0003 -> one output write with paddr 32'h0001_2345, pwdata 16'hBEEF; SETUP then ACCESS; CTRL reads back 16'h0006.
- Proxy read: ADDR=32'h0000_0010, CTRL=16'h0001, slave returns 16'hA5A5 after 3 wait cycles -> DATA reads back 16'hA5A5; CTRL reads 16'h0004.
- Bypass read at req_paddr 21'h00_0100, slave responds 16'h1234 -> out_paddr 32'h0020_0100; req_pready pulses 1 cycle with prdata 16'h1234, pslverr 0.
- Bypass with slave silent, TIMEOUT=8 -> abort after 8 ACCESS cycles; req_prdata 16'hFFFF, req_pslverr 1. Repeat with out_pready arriving on cycle 8 -> normal completion.
- Proxy write with out_pslverr=1 -> CTRL reads 16'h000E; a following CTRL write of 16'h0001 clears err before launch.
- Bypass request issued during PX_ACCESS -> stalls (no req_pready) until the proxy transaction completes, then is forwarded. Also: assert rstn mid-BYP_ACCESS -> all outputs 0 next cycle, registers cleared.
